// File: rtl/msb_pkg.sv
// rtl/msb_pkg.sv - shared widths, beat enum and BRAM address packing for the multi-stream buffer
package msb_pkg;

  localparam int DATA_WIDTH      = 64;
  localparam int WAYS            = 8;
  localparam int l1_nstrms       = 16;
  localparam int l1_ncl          = 16;
  localparam int l1_nstrms_width = $clog2(l1_nstrms);
  localparam int l1_ncl_width    = $clog2(l1_ncl);
  localparam int ADDR_WIDTH      = l1_nstrms_width + l1_ncl_width + 1;
  localparam int BEAT_WIDTH      = WAYS * DATA_WIDTH;
  localparam int CNT_WIDTH       = l1_ncl_width + 1;

  typedef enum logic {
    BEAT0 = 1'b0,
    BEAT1 = 1'b1
  } beat_e;

  // A line occupies an even/odd address pair inside its stream's slot range.
  function automatic logic [ADDR_WIDTH-1:0] pack_addr(
    input logic [l1_nstrms_width-1:0] st,
    input logic [l1_ncl_width-1:0]    cl,
    input beat_e                      beat
  );
    return {st, cl, logic'(beat)};
  endfunction

endpackage

// File: rtl/stream_occ_tbl.sv
// rtl/stream_occ_tbl.sv - per-stream line count, read and write pointers with commit/release/alloc
module stream_occ_tbl
  import msb_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [l1_nstrms_width-1:0]          i_alloc_st,
  output logic [l1_ncl_width-1:0]             o_alloc_slot,
  input  logic                                i_adv_v,
  input  logic [l1_nstrms_width-1:0]          i_adv_st,
  input  logic                                i_commit_v,
  input  logic [l1_nstrms_width-1:0]          i_commit_st,
  input  logic                                i_rel_v,
  input  logic [l1_nstrms_width-1:0]          i_rel_st,
  output logic [l1_nstrms-1:0]                o_full,
  output logic [l1_nstrms-1:0]                o_nempty,
  output logic [l1_nstrms*l1_ncl_width-1:0]   o_rptr,
  output logic                                o_err
);

  logic [CNT_WIDTH-1:0]    r_cnt  [l1_nstrms];
  logic [l1_ncl_width-1:0] r_rptr [l1_nstrms];
  logic [l1_ncl_width-1:0] r_wptr [l1_nstrms];
  logic                    r_err;

  logic [l1_nstrms-1:0] w_inc;
  logic [l1_nstrms-1:0] w_dec;
  logic [l1_nstrms-1:0] w_adv;

  // A line between beat-1 accept and its commit still owns its slot, so it counts toward full.
  always_comb begin
    w_inc    = '0;
    w_dec    = '0;
    w_adv    = '0;
    o_full   = '0;
    o_nempty = '0;
    o_rptr   = '0;
    for (int s = 0; s < l1_nstrms; s++) begin
      w_inc[s]    = i_commit_v && (i_commit_st == l1_nstrms_width'(s));
      w_dec[s]    = i_rel_v && (i_rel_st == l1_nstrms_width'(s)) && (r_cnt[s] != '0);
      w_adv[s]    = i_adv_v && (i_adv_st == l1_nstrms_width'(s));
      o_full[s]   = (r_cnt[s] == CNT_WIDTH'(l1_ncl)) ||
                    (w_inc[s] && (r_cnt[s] == CNT_WIDTH'(l1_ncl - 1)));
      o_nempty[s] = (r_cnt[s] != '0);
      o_rptr[s*l1_ncl_width +: l1_ncl_width] = r_rptr[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < l1_nstrms; s++) begin
        r_cnt[s]  <= '0;
        r_rptr[s] <= '0;
        r_wptr[s] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int s = 0; s < l1_nstrms; s++) begin
        case ({w_inc[s], w_dec[s]})
          2'b10:   r_cnt[s] <= r_cnt[s] + CNT_WIDTH'(1);
          2'b01:   r_cnt[s] <= r_cnt[s] - CNT_WIDTH'(1);
          default: r_cnt[s] <= r_cnt[s];
        endcase
        if (w_dec[s]) r_rptr[s] <= r_rptr[s] + l1_ncl_width'(1);
        if (w_adv[s]) r_wptr[s] <= r_wptr[s] + l1_ncl_width'(1);
      end
      if (i_rel_v && (r_cnt[i_rel_st] == '0)) r_err <= 1'b1;
    end
  end

  assign o_alloc_slot = r_wptr[i_alloc_st];
  assign o_err        = r_err;

endmodule

// File: rtl/l1_stream_fill_ctrl.sv
// rtl/l1_stream_fill_ctrl.sv - two-beat line fill FSM driving one BRAM write channel
module l1_stream_fill_ctrl
  import msb_pkg::*;
(
  input  logic                                clk1x,
  input  logic                                reset,
  input  logic                                i_v,
  output logic                                i_r,
  input  logic [l1_nstrms_width-1:0]          i_st,
  input  logic [BEAT_WIDTH-1:0]               i_d,
  input  logic                                i_rel_v,
  input  logic [l1_nstrms_width-1:0]          i_rel_st,
  output logic                                o_we,
  output logic [ADDR_WIDTH-1:0]               o_wa,
  output logic [BEAT_WIDTH-1:0]               o_wd,
  output logic [l1_nstrms-1:0]                o_nempty,
  output logic [l1_nstrms*l1_ncl_width-1:0]   o_rptr,
  output logic                                o_err
);

  beat_e                      r_state;
  logic [l1_nstrms_width-1:0] r_st_q;
  logic [l1_ncl_width-1:0]    r_slot_q;
  logic                       r_we;
  logic [ADDR_WIDTH-1:0]      r_wa;
  logic [BEAT_WIDTH-1:0]      r_wd;
  logic                       r_commit_v;
  logic [l1_nstrms_width-1:0] r_commit_st;

  logic [l1_nstrms-1:0]       w_full;
  logic [l1_ncl_width-1:0]    w_alloc_slot;
  logic                       w_acc;
  logic                       w_adv;

  assign i_r   = !reset && ((r_state == BEAT1) || !w_full[i_st]);
  assign w_acc = i_v && i_r;
  assign w_adv = w_acc && (r_state == BEAT1);

  // Commit trails the beat-1 write by one edge so the BRAM holds the line before o_nempty rises.
  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      r_state     <= BEAT0;
      r_st_q      <= '0;
      r_slot_q    <= '0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_commit_v  <= 1'b0;
      r_commit_st <= '0;
    end else begin
      r_we        <= w_acc;
      r_commit_v  <= w_adv;
      r_commit_st <= r_st_q;
      if (w_acc) begin
        r_wd <= i_d;
        case (r_state)
          BEAT0: begin
            r_st_q   <= i_st;
            r_slot_q <= w_alloc_slot;
            r_wa     <= pack_addr(i_st, w_alloc_slot, BEAT0);
            r_state  <= BEAT1;
          end
          BEAT1: begin
            r_wa    <= pack_addr(r_st_q, r_slot_q, BEAT1);
            r_state <= BEAT0;
          end
          default: r_state <= BEAT0;
        endcase
      end
    end
  end

  stream_occ_tbl u_occ (
    .clk          (clk1x),
    .rst          (reset),
    .i_alloc_st   (i_st),
    .o_alloc_slot (w_alloc_slot),
    .i_adv_v      (w_adv),
    .i_adv_st     (r_st_q),
    .i_commit_v   (r_commit_v),
    .i_commit_st  (r_commit_st),
    .i_rel_v      (i_rel_v),
    .i_rel_st     (i_rel_st),
    .o_full       (w_full),
    .o_nempty     (o_nempty),
    .o_rptr       (o_rptr),
    .o_err        (o_err)
  );

  assign o_we = r_we;
  assign o_wa = r_wa;
  assign o_wd = r_wd;

endmodule

// File: tb/tb_l1_stream_fill_ctrl.sv
// tb/tb_l1_stream_fill_ctrl.sv - scoreboard bench for l1_stream_fill_ctrl with a line-level reference model
module tb_l1_stream_fill_ctrl;
  import msb_pkg::*;

  logic         clk1x = 1'b0;
  logic         reset;
  logic         i_v;
  logic         i_r;
  logic [3:0]   i_st;
  logic [511:0] i_d;
  logic         i_rel_v;
  logic [3:0]   i_rel_st;
  logic         o_we;
  logic [8:0]   o_wa;
  logic [511:0] o_wd;
  logic [15:0]  o_nempty;
  logic [63:0]  o_rptr;
  logic         o_err;

  l1_stream_fill_ctrl dut (
    .clk1x    (clk1x),
    .reset    (reset),
    .i_v      (i_v),
    .i_r      (i_r),
    .i_st     (i_st),
    .i_d      (i_d),
    .i_rel_v  (i_rel_v),
    .i_rel_st (i_rel_st),
    .o_we     (o_we),
    .o_wa     (o_wa),
    .o_wd     (o_wd),
    .o_nempty (o_nempty),
    .o_rptr   (o_rptr),
    .o_err    (o_err)
  );

  always #5 clk1x = ~clk1x;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk1x) cyc++;

  typedef struct {
    logic [8:0]   wa;
    logic [511:0] wd;
    int           stamp;
  } wr_t;
  wr_t exp_q[$];

  // Reference model: committed lines, lines owning a slot, pointers, one line in progress.
  int m_cnt[16];
  int m_occ[16];
  int m_rptr[16];
  int m_wptr[16];
  bit m_err;
  bit m_in_line;
  int m_line_st;
  int m_line_slot;
  bit m_pend_v;
  int m_pend_st;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rnd_d();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 16; s++) begin
      m_cnt[s] = 0; m_occ[s] = 0; m_rptr[s] = 0; m_wptr[s] = 0;
    end
    m_err = 0; m_in_line = 0; m_line_st = 0; m_line_slot = 0;
    m_pend_v = 0; m_pend_st = 0;
  endtask

  always @(negedge clk1x) begin
    if (!reset) begin
      if (o_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual_wa=%0d expected=no write (cycle %0d)", o_wa, cyc);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (o_wa !== e.wa || o_wd !== e.wd || cyc != e.stamp) begin
            failures++;
            $display("FAIL write actual_wa=%0d expected_wa=%0d actual_cycle=%0d expected_cycle=%0d wd_match=%0d",
                     o_wa, e.wa, cyc, e.stamp, (o_wd === e.wd));
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_write actual=no write expected_wa=%0d (cycle %0d)", exp_q[0].wa, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit v, input int st, input logic [511:0] d, input bit rv, input int rs);
    logic [15:0] exp_ne;
    logic [63:0] exp_rp;
    bit          exp_r;
    wr_t         w;
    @(negedge clk1x);
    #1;
    for (int s = 0; s < 16; s++) begin
      exp_ne[s]        = (m_cnt[s] != 0);
      exp_rp[s*4 +: 4] = 4'(m_rptr[s]);
    end
    chk("o_nempty", 64'(o_nempty), 64'(exp_ne));
    chk("o_rptr", o_rptr, exp_rp);
    chk("o_err", 64'(o_err), 64'(m_err));
    i_v = v; i_st = 4'(st); i_d = d; i_rel_v = rv; i_rel_st = 4'(rs);
    #1;
    exp_r = m_in_line ? 1'b1 : (m_occ[st] < 16);
    chk("i_r", 64'(i_r), 64'(exp_r));
    if (rv) begin
      if (m_cnt[rs] > 0) begin
        m_cnt[rs]--; m_occ[rs]--; m_rptr[rs] = (m_rptr[rs] + 1) % 16;
      end else begin
        m_err = 1;
      end
    end
    if (m_pend_v) begin
      m_cnt[m_pend_st]++;
      m_pend_v = 0;
    end
    if (v && exp_r) begin
      w.wd = d;
      w.stamp = cyc + 1;
      if (!m_in_line) begin
        m_in_line = 1; m_line_st = st; m_line_slot = m_wptr[st];
        w.wa = 9'(st * 32 + m_line_slot * 2);
      end else begin
        w.wa = 9'(m_line_st * 32 + m_line_slot * 2 + 1);
        m_wptr[m_line_st] = (m_wptr[m_line_st] + 1) % 16;
        m_occ[m_line_st]++;
        m_in_line = 0;
        m_pend_v = 1; m_pend_st = m_line_st;
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk1x);
    #1;
    reset = 1'b1; i_v = 1'b0; i_rel_v = 1'b0;
    #1;
    chk("rst_o_we", 64'(o_we), 64'd0);
    chk("rst_o_wa", 64'(o_wa), 64'd0);
    chk("rst_o_wd", 64'(|o_wd), 64'd0);
    chk("rst_o_nempty", 64'(o_nempty), 64'd0);
    chk("rst_o_rptr", o_rptr, 64'd0);
    chk("rst_o_err", 64'(o_err), 64'd0);
    chk("rst_i_r", 64'(i_r), 64'd0);
    model_clear();
    exp_q.delete();
    @(negedge clk1x);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_v = 0; i_st = 0; i_d = '0; i_rel_v = 0; i_rel_st = 0;
    model_clear();
    repeat (2) @(negedge clk1x);
    reset_pulse();

    step(1, 1, rnd_d(), 0, 0);
    step(1, 1, rnd_d(), 0, 0);
    idle(3);

    for (int i = 0; i < 32; i++) step(1, 2, rnd_d(), 0, 0);
    step(1, 2, rnd_d(), 0, 0);
    step(1, 3, rnd_d(), 0, 0);
    step(1, 3, rnd_d(), 0, 0);
    idle(2);

    step(0, 0, '0, 1, 2);
    step(1, 2, rnd_d(), 0, 0);
    step(1, 2, rnd_d(), 0, 0);
    idle(2);

    step(1, 4, rnd_d(), 0, 0);
    step(1, 4, rnd_d(), 0, 0);
    idle(2);
    step(1, 4, rnd_d(), 0, 0);
    step(1, 4, rnd_d(), 0, 0);
    step(0, 0, '0, 1, 4);
    idle(2);

    step(0, 0, '0, 1, 5);
    idle(2);

    step(1, 6, rnd_d(), 0, 0);
    reset_pulse();
    step(1, 6, rnd_d(), 0, 0);
    step(1, 6, rnd_d(), 0, 0);
    idle(3);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 5), rnd_d(),
           ($urandom_range(0, 9) < 3), $urandom_range(0, 5));
    end
    idle(4);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
